acct_access_arbiter: RTL and testbench
======================================

# acct_access_arbiter

Arbitrates between `NB_REQ` requesters (e.g. boot firmware port, debug port) that need read/write access to the access-control register file.
It sequences each access as one single-cycle register-file transaction and enforces register-lock policy before the transaction is issued.
It returns a per-requester response with read data or an error flag.
It sits between the requesters and the access-control register file's `en/we/address/wdata/rdata` port; the register file keeps its own lock checks as a second line of defence.

## Interface
Parameters:
- `NB_REQ`, default 2: number of requesters (2..8).
- `NB_WORDS`, default 10: number of 32-bit access-control words implemented.
- `AXI_ADDR_WIDTH`, default 64: width of `reg_addr_o`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `reglk_ctrl_i`, input, 8: lock vector. For group `g = idx/3`, `g` in 0..3:
  - write lock = bit `2g+1`;
  - read lock = bit `2g`.
- `req_valid_i`, input, `NB_REQ`: request valid, one bit per requester.
- `req_ready_o`, output, `NB_REQ`: one-hot acceptance strobe.
- `req_we_i`, input, `NB_REQ`: 1 = write, 0 = read.
- `req_idx_i`, input, `NB_REQ*8`: word index per requester, packed with requester `r` at bits `[8r+7:8r]`.
- `req_wdata_i`, input, `NB_REQ*32`: write data, packed the same way.
- `rsp_valid_o`, output, `NB_REQ`: one-hot response strobe.
- `rsp_rdata_o`, output, 32: read data, shared by all requesters.
- `rsp_err_o`, output, 1: error flag, valid with `rsp_valid_o`.
- `reg_en_o`, output, 1: register-file access enable.
- `reg_we_o`, output, 1: register-file write enable.
- `reg_addr_o`, output, `AXI_ADDR_WIDTH`: register-file byte address, equal to `idx << 3`.
- `reg_wdata_o`, output, 64: register-file write data, `{32'b0, wdata}`.
- `reg_rdata_i`, input, 64: combinational read data from the register file. Only bits `[31:0]` are used.
- `err_count_o`, output, 16: saturating count of error responses.

## Operation
- The FSM has three states: `IDLE`, `ISSUE`, `RESP`.
- `IDLE`:
  - If any `req_valid_i` bit is set, select the winner round-robin, starting the search at `rr_ptr`.
  - Assert `req_ready_o[winner]` combinationally in that cycle.
  - Capture the winner's `we`, `idx`, `wdata` and requester number.
  - Set `rr_ptr = (winner+1) mod NB_REQ`.
  - Go to `ISSUE`.
  - If no request is valid, stay in `IDLE`.
- Policy check is performed on the captured request. The request is an error if any of the following holds:
  - `idx >= NB_WORDS`;
  - it is a write and the group's write lock is set;
  - it is a read and the group's read lock is set.
- `ISSUE`:
  - If the request is not an error, drive `reg_en_o=1`, `reg_we_o=we`, `reg_addr_o`, `reg_wdata_o`.
  - For a read, register `reg_rdata_i[31:0]` at the end of this cycle.
  - If the request is an error, `reg_en_o` stays 0; the register file is never touched.
  - Always go to `RESP`.
- `RESP`:
  - Assert `rsp_valid_o[captured requester]=1`.
  - Drive `rsp_err_o` from the policy check.
  - `rsp_rdata_o` = captured read data for a successful read; 0 for a write or any error.
  - If `rsp_err_o=1`, increment `err_count_o`, saturating at `16'hFFFF`.
  - Go to `IDLE`.
- Requesters hold `valid`, `we`, `idx` and `wdata` stable until they see `ready`. A requester may deassert `valid` without being accepted.
- `req_ready_o` and `reg_en_o` are never asserted outside `IDLE` and `ISSUE` respectively.
- A lock change during `ISSUE` or `RESP` does not alter an already-evaluated policy result.

## Timing
- Reset (asynchronous assert, synchronous deassert within the clock domain):
  - state = `IDLE`, `rr_ptr = 0`;
  - every output is 0, including `err_count_o`;
  - a transaction in flight is dropped with no response.
- Latency: a request accepted in cycle N gets `reg_en_o` in N+1 and `rsp_valid_o` in N+2.
- Peak throughput: one transaction per 3 cycles. A new acceptance can happen in N+3.
- `rsp_valid_o`, `rsp_err_o` and `rsp_rdata_o` are one-cycle pulses; outside `RESP` they are 0.
- Simultaneous valid requests: exactly one is accepted per `IDLE` cycle. The losers keep waiting.
- Round-robin fairness: with all requesters continuously valid, each requester is granted at least once every `NB_REQ` transactions.

## Test plan
- Single write, then read back:
  - Stimulus: req0 writes `idx 4` with `0xA5A5_0001` while `reglk=0`, then reads `idx 4`.
  - Required response: `reg_en_o` pulses with `reg_addr_o=0x20`, `reg_wdata_o=0x0000_0000_A5A5_0001`; the read returns `0xA5A5_0001`, `err=0`; each response arrives 2 cycles after acceptance.
- Locked write:
  - Stimulus: `reglk=8'h02`, req1 writes `idx 1`.
  - Required response: `reg_en_o` never asserts, `rsp_err_o=1`, `rsp_rdata_o=0`, `err_count_o` goes 0→1.
- Locked read:
  - Stimulus: `reglk=8'h04`, read `idx 5`.
  - Required response: `err=1`, `rdata=0`.
  - With the same lock, a read of `idx 0` succeeds.
- Out of range and saturation:
  - Stimulus: read `idx 10`; separately, force 65,536 errors.
  - Required response: `idx 10` gives `err=1` with no `reg_en_o`; `err_count_o` holds at `0xFFFF` after the 65,536 errors.
- Round-robin:
  - Stimulus: both requesters continuously valid for 6 transactions from reset.
  - Required response: grant order 0, 1, 0, 1, 0, 1; `rsp_valid_o` is one-hot each time and matches the granted requester.
- Reset mid-operation:
  - Stimulus: assert `rst_ni=0` in the `ISSUE` cycle.
  - Required response: all outputs go to 0 immediately; no `rsp_valid_o` is ever produced for that request; after release the next grant goes to req0.

Source files
------------

// File: rtl/acct_access_arbiter_if.sv
// Requester and register-file port bundle for acct_access_arbiter.
// The arbiter takes the slave view. Requesters and the register file take the master view.
interface acct_access_arbiter_if #(
  parameter int NB_REQ         = 2,
  parameter int AXI_ADDR_WIDTH = 64
);
  logic [NB_REQ-1:0]         req_valid_i;
  logic [NB_REQ-1:0]         req_ready_o;
  logic [NB_REQ-1:0]         req_we_i;
  logic [NB_REQ*8-1:0]       req_idx_i;
  logic [NB_REQ*32-1:0]      req_wdata_i;
  logic [NB_REQ-1:0]         rsp_valid_o;
  logic [31:0]               rsp_rdata_o;
  logic                      rsp_err_o;
  logic                      reg_en_o;
  logic                      reg_we_o;
  logic [AXI_ADDR_WIDTH-1:0] reg_addr_o;
  logic [63:0]               reg_wdata_o;
  logic [63:0]               reg_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_idx_i, req_wdata_i, reg_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           reg_en_o, reg_we_o, reg_addr_o, reg_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_idx_i, req_wdata_i, reg_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           reg_en_o, reg_we_o, reg_addr_o, reg_wdata_o
  );
endinterface

// File: rtl/acct_access_arbiter.sv
// Round-robin arbiter that gives requesters access to the access-control register file.
// It checks lock policy before each single-cycle transaction and returns a response with data or an error flag.
module acct_access_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int NB_WORDS       = 10,
  parameter int AXI_ADDR_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           reglk_ctrl_i,
  acct_access_arbiter_if.slave bus,
  output logic [15:0]          err_count_o
);

  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   winner;
  logic            found;
  logic [7:0]      win_idx;
  logic            win_we;
  logic [7:0]      win_grp;
  logic            win_lock;
  logic            win_err;

  logic            cap_we;
  logic [7:0]      cap_idx;
  logic [31:0]     cap_wdata;
  logic [PW-1:0]   cap_req;
  logic            cap_err;
  logic [31:0]     rdata_q;
  logic [15:0]     err_count;
  logic            unused_rdata_hi;

  assign unused_rdata_hi = ^bus.reg_rdata_i[63:32];
  assign err_count_o     = err_count;

  // Search for the winner starting at rr_ptr and wrapping around.
  always_comb begin
    int cand;
    // NOTE: every variable written here gets a default first; otherwise a latch is inferred.
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      if (!found && bus.req_valid_i[cand]) begin
        found  = 1'b1;
        winner = PW'(cand);
      end
    end
  end

  // Check the policy on the winning request. The result is captured at acceptance,
  // so a later change to the locks cannot alter it.
  always_comb begin
    win_idx  = bus.req_idx_i[8*winner +: 8];
    win_we   = bus.req_we_i[winner];
    win_grp  = win_idx / 8'd3;
    win_lock = win_we ? reglk_ctrl_i[{win_grp[1:0], 1'b1}]
                      : reglk_ctrl_i[{win_grp[1:0], 1'b0}];
    win_err  = (int'(win_idx) >= NB_WORDS) || ((win_grp < 8'd4) && win_lock);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.rsp_err_o   = 1'b0;
    bus.rsp_rdata_o = '0;
    bus.reg_en_o    = 1'b0;
    bus.reg_we_o    = 1'b0;
    bus.reg_addr_o  = '0;
    bus.reg_wdata_o = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          // Ready is held low while reset is asserted, so every output stays at 0 during reset.
          bus.req_ready_o[winner] = rst_ni;
          state_nxt               = ISSUE;
        end
      end
      ISSUE: begin
        bus.reg_en_o    = !cap_err;
        bus.reg_we_o    = !cap_err && cap_we;
        bus.reg_addr_o  = cap_err ? '0 : AXI_ADDR_WIDTH'({cap_idx, 3'b000});
        bus.reg_wdata_o = cap_err ? '0 : {32'h0, cap_wdata};
        state_nxt       = RESP;
      end
      RESP: begin
        bus.rsp_valid_o[cap_req] = 1'b1;
        bus.rsp_err_o            = cap_err;
        bus.rsp_rdata_o          = rdata_q;
        state_nxt                = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: these are a handful of control flops, not a memory array, so all of them are reset
      // and a dropped transaction leaves nothing stale behind.
      rr_ptr    <= '0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_req   <= '0;
      cap_err   <= 1'b0;
      rdata_q   <= '0;
      err_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            cap_we    <= win_we;
            cap_idx   <= win_idx;
            cap_wdata <= bus.req_wdata_i[32*winner +: 32];
            cap_req   <= winner;
            cap_err   <= win_err;
            rr_ptr    <= (winner == PW'(NB_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        ISSUE: rdata_q <= (!cap_err && !cap_we) ? bus.reg_rdata_i[31:0] : 32'h0;
        RESP: begin
          if (cap_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acct_access_arbiter.sv
// Directed bench for acct_access_arbiter: reset state, lock policy, read-back, saturation,
// round-robin order and reset in mid-transaction.
module tb_acct_access_arbiter;
  localparam int NB_REQ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  reglk;
  logic [15:0] err_count;
  logic [31:0] mem [0:15];
  int          en_cnt  = 0;
  int          rsp_cnt = 0;
  int          total   = 0;
  int          bad     = 0;

  always #5 clk = ~clk;

  acct_access_arbiter_if #(.NB_REQ(NB_REQ), .AXI_ADDR_WIDTH(64)) bus ();

  acct_access_arbiter #(.NB_REQ(NB_REQ), .NB_WORDS(10), .AXI_ADDR_WIDTH(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .reglk_ctrl_i (reglk),
    .bus          (bus.slave),
    .err_count_o  (err_count)
  );

  // Register file model. The upper read bits are nonzero so the test shows they are ignored.
  assign bus.reg_rdata_i = {32'hFFFF_FFFF, mem[bus.reg_addr_o[6:3]]};

  always @(posedge clk) begin
    if (bus.reg_en_o) begin
      en_cnt <= en_cnt + 1;
      if (bus.reg_we_o) mem[bus.reg_addr_o[6:3]] <= bus.reg_wdata_o[31:0];
    end
    if (bus.rsp_valid_o != '0) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic txn(input int r, input logic we, input logic [7:0] idx, input logic [31:0] wd,
                     input logic exp_en, input logic exp_err, input logic [31:0] exp_rd,
                     input logic [15:0] exp_cnt, input string tag);
    int w;
    logic [NB_REQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    @(negedge clk);
    bus.req_valid_i[r]           = 1'b1;
    bus.req_we_i[r]              = we;
    bus.req_idx_i[8*r +: 8]      = idx;
    bus.req_wdata_i[32*r +: 32]  = wd;
    w = 0;
    #1;
    while (bus.req_ready_o == '0 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, "_ready"}, 64'(bus.req_ready_o), 64'(oh));
    @(posedge clk);
    #1 bus.req_valid_i[r] = 1'b0;
    @(negedge clk);
    check({tag, "_en"}, 64'(bus.reg_en_o), 64'(exp_en));
    if (exp_en) begin
      check({tag, "_we"}, 64'(bus.reg_we_o), 64'(we));
      check({tag, "_addr"}, bus.reg_addr_o, 64'({idx, 3'b000}));
      if (we) check({tag, "_wdata"}, bus.reg_wdata_o, {32'h0, wd});
    end
    @(negedge clk);
    check({tag, "_rspv"}, 64'(bus.rsp_valid_o), 64'(oh));
    check({tag, "_err"}, 64'(bus.rsp_err_o), 64'(exp_err));
    check({tag, "_rdata"}, 64'(bus.rsp_rdata_o), 64'(exp_rd));
    @(negedge clk);
    check({tag, "_rsp_pulse"}, 64'(bus.rsp_valid_o), 64'(0));
    check({tag, "_errcnt"}, 64'(err_count), 64'(exp_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int snap;
    logic [NB_REQ-1:0] exp_g;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.req_valid_i = '0;
    bus.req_we_i    = '0;
    bus.req_idx_i   = '0;
    bus.req_wdata_i = '0;
    reglk           = 8'h00;
    do_reset();

    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready_o), 64'(0));
    check("rst_rspv", 64'(bus.rsp_valid_o), 64'(0));
    check("rst_en", 64'(bus.reg_en_o), 64'(0));
    check("rst_addr", bus.reg_addr_o, 64'(0));
    check("rst_errcnt", 64'(err_count), 64'(0));

    txn(0, 1'b1, 8'd4, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0, 16'd0, "wr4");
    txn(0, 1'b0, 8'd4, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001, 16'd0, "rd4");

    reglk = 8'h02;
    txn(1, 1'b1, 8'd1, 32'h1111_2222, 1'b0, 1'b1, 32'h0, 16'd1, "wr1_locked");

    reglk = 8'h04;
    txn(0, 1'b0, 8'd5, 32'h0, 1'b0, 1'b1, 32'h0, 16'd2, "rd5_locked");
    txn(1, 1'b1, 8'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 16'd2, "wr0_open");
    txn(0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 16'd2, "rd0_open");

    reglk = 8'h00;
    txn(1, 1'b0, 8'd10, 32'h0, 1'b0, 1'b1, 32'h0, 16'd3, "rd10_oor");
    txn(0, 1'b1, 8'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 16'd3, "wr9");
    txn(1, 1'b0, 8'd9, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 16'd3, "rd9");

    reglk = 8'hC0;
    txn(0, 1'b0, 8'd9, 32'h0, 1'b0, 1'b1, 32'h0, 16'd4, "rd9_locked");
    check("en_total", 64'(en_cnt), 64'(6));

    // Preload the counter close to saturation instead of generating 65,534 errors.
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    #1 release dut.err_count;
    reglk = 8'h00;
    txn(0, 1'b0, 8'd12, 32'h0, 1'b0, 1'b1, 32'h0, 16'hFFFF, "sat1");
    txn(1, 1'b1, 8'd200, 32'h5, 1'b0, 1'b1, 32'h0, 16'hFFFF, "sat2");

    do_reset();
    check("rst2_errcnt", 64'(err_count), 64'(0));
    bus.req_valid_i = 2'b11;
    bus.req_we_i    = 2'b00;
    bus.req_idx_i   = {8'd3, 8'd2};
    for (int t = 0; t < 6; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      #1;
      while (bus.req_ready_o == '0 && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      check($sformatf("rr%0d_grant", t), 64'(bus.req_ready_o), 64'(exp_g));
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rr%0d_rspv", t), 64'(bus.rsp_valid_o), 64'(exp_g));
      @(negedge clk);
    end
    bus.req_valid_i = '0;

    @(negedge clk);
    bus.req_valid_i[0] = 1'b1;
    #1 check("mid_ready", 64'(bus.req_ready_o), 64'(1));
    @(posedge clk);
    #1 bus.req_valid_i[0] = 1'b0;
    @(negedge clk);
    check("mid_issue_en", 64'(bus.reg_en_o), 64'(1));
    snap = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 64'(bus.reg_en_o), 64'(0));
    check("mid_rst_addr", bus.reg_addr_o, 64'(0));
    check("mid_rst_rspv", 64'(bus.rsp_valid_o), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_no_rsp", 64'(rsp_cnt), 64'(snap));
    bus.req_valid_i = 2'b11;
    #1 check("mid_next_grant", 64'(bus.req_ready_o), 64'(1));
    bus.req_valid_i = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
